regfile_write_bank: RTL and testbench
=====================================

Name: regfile_write_bank

Overview:
- Write side and storage of the 32-entry register bank.
- A 5-to-32 one-hot decoder steers a single write port into 32 N-bit registers.
- All 32 register contents are exposed in parallel as q00..q31. These outputs drive the 32-input read-port selectors.
- A sequential bulk-clear engine zeroes the bank one register per cycle, with a valid/ready handshake on the write port.

Parameters:
N, 32, data width of each register and of wr_data.
ZERO_REG, 1, when 1, register 0 is hardwired to zero and writes to address 0 are discarded. When 0, register 0 is an ordinary register.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
wr_valid  input  1  write request valid.
wr_ready  output  1  write port can accept; handshake completes on the edge where wr_valid && wr_ready.
wr_addr  input  5  destination register index, 0..31.
wr_data  input  N  data to write.
clear_req  input  1  request a bulk clear of all 32 registers.
busy  output  1  high while the clear engine is running.
q00..q31  output  N each  current contents of registers 0..31 (registered, no combinational path from inputs).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous): all q00..q31 = 0; state = IDLE; clear counter = 0; busy = 0. Asserting reset mid-clear aborts the clear and returns to IDLE with all registers zero.
- States:
  - IDLE: writes accepted.
  - CLEAR: counter walks 0..31.
- wr_ready = (state == IDLE) && !clear_req. This is combinational. clear_req has priority over a same-cycle write; that write is not accepted and the source must hold it.
- busy = (state == CLEAR). It is a registered state decode.
- Write:
  - On an accepted handshake, the decoder raises exactly one enable, for wr_addr.
  - That register loads wr_data at the edge; the new value appears on q<addr> in the next cycle (1-cycle latency).
  - All other registers hold.
  - If ZERO_REG=1 and wr_addr=0: the handshake still completes (wr_ready unaffected), the data is discarded, and q00 stays 0.
  - Back-to-back writes, one per cycle, are supported with no bubbles.
  - Repeated writes to the same address: the last accepted write wins.
- Clear:
  - Start: clear_req high in IDLE → next edge enters CLEAR with counter = 0.
  - Sweep: in each CLEAR cycle, register[counter] is zeroed at the edge and counter increments.
  - End: on the edge that clears register 31, state returns to IDLE and counter wraps to 0.
  - Timing: busy is high for exactly 32 cycles; wr_ready is next high in the 33rd cycle after the request edge, if clear_req is low by then.
  - clear_req held or re-asserted during CLEAR is ignored; there is no restart and no queuing.
  - clear_req still high when the engine returns to IDLE starts a new clear.
- Widths: wr_addr is a full 5-bit index, so no out-of-range case exists. No arithmetic on data; the counter is 5 bits and wraps modulo 32.
- wr_valid while busy: no write, no side effect; the request is held by the source.

Test Plan:
- Reset, then write addr=5 data=0xDEADBEEF with wr_valid for 1 cycle → q05=0xDEADBEEF on the following cycle; all other q = 0; wr_ready stays 1.
- ZERO_REG=1: write addr=0 data=0xFFFFFFFF → handshake completes, q00 remains 0. Repeat with ZERO_REG=0 → q00=0xFFFFFFFF.
- Back-to-back writes addr=i data=i*0x01010101 for i=1..31 over 31 consecutive cycles → each q<i> holds its value; no write lost.
- Fill all registers with nonzero values, pulse clear_req 1 cycle:
  - busy high for exactly 32 cycles.
  - q00..q31 reach zero in index order, one per cycle.
  - wr_ready low throughout and high again in cycle 33.
- Assert wr_valid addr=7 data=0x1234 together with clear_req in IDLE → wr_ready=0 that cycle. Hold wr_valid → the write completes in the first IDLE cycle after the clear; q07=0x1234 and all others 0.
- Start a clear, drop rst_n after 10 CLEAR cycles → all q=0, busy=0, wr_ready=1 immediately after release; a new write then lands normally.

Source files
------------

// File: rtl/regfile_write_bank.sv
// 32-entry register bank: one-hot decoded single write port, parallel q00..q31
// outputs, and a one-register-per-cycle bulk-clear engine with valid/ready handshake.
module regfile_write_bank #(
  parameter int N        = 32,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         clear_req,
  output logic         busy,
  output logic [N-1:0] q00,
  output logic [N-1:0] q01,
  output logic [N-1:0] q02,
  output logic [N-1:0] q03,
  output logic [N-1:0] q04,
  output logic [N-1:0] q05,
  output logic [N-1:0] q06,
  output logic [N-1:0] q07,
  output logic [N-1:0] q08,
  output logic [N-1:0] q09,
  output logic [N-1:0] q10,
  output logic [N-1:0] q11,
  output logic [N-1:0] q12,
  output logic [N-1:0] q13,
  output logic [N-1:0] q14,
  output logic [N-1:0] q15,
  output logic [N-1:0] q16,
  output logic [N-1:0] q17,
  output logic [N-1:0] q18,
  output logic [N-1:0] q19,
  output logic [N-1:0] q20,
  output logic [N-1:0] q21,
  output logic [N-1:0] q22,
  output logic [N-1:0] q23,
  output logic [N-1:0] q24,
  output logic [N-1:0] q25,
  output logic [N-1:0] q26,
  output logic [N-1:0] q27,
  output logic [N-1:0] q28,
  output logic [N-1:0] q29,
  output logic [N-1:0] q30,
  output logic [N-1:0] q31
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]   state;
  logic [4:0]   clr_cnt;
  logic         wr_fire;
  logic         wr_keep;
  logic [31:0]  wr_en;
  logic [31:0]  clr_en;
  logic [N-1:0] regs [32];

  // clear_req wins over a same-cycle write; the source keeps wr_valid up.
  assign wr_ready = (state == S_IDLE) && !clear_req;
  assign busy     = (state == S_CLEAR);
  assign wr_fire  = wr_valid && wr_ready;
  // A write to the hardwired zero register still handshakes but enables nothing.
  assign wr_keep  = !((ZERO_REG != 0) && (wr_addr == 5'd0));

  always_comb begin
    wr_en  = '0;
    clr_en = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      wr_en[i]  = wr_fire && wr_keep && (wr_addr == 5'(i));
      clr_en[i] = busy && (clr_cnt == 5'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          clr_cnt <= '0;
          if (clear_req) state <= S_CLEAR;
        end
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 5'd1;
          if (clr_cnt == 5'd31) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        regs[g] <= '0;
      else if (clr_en[g])
        regs[g] <= '0;
      else if (wr_en[g])
        regs[g] <= wr_data;
    end
  end

  assign q00 = regs[0];
  assign q01 = regs[1];
  assign q02 = regs[2];
  assign q03 = regs[3];
  assign q04 = regs[4];
  assign q05 = regs[5];
  assign q06 = regs[6];
  assign q07 = regs[7];
  assign q08 = regs[8];
  assign q09 = regs[9];
  assign q10 = regs[10];
  assign q11 = regs[11];
  assign q12 = regs[12];
  assign q13 = regs[13];
  assign q14 = regs[14];
  assign q15 = regs[15];
  assign q16 = regs[16];
  assign q17 = regs[17];
  assign q18 = regs[18];
  assign q19 = regs[19];
  assign q20 = regs[20];
  assign q21 = regs[21];
  assign q22 = regs[22];
  assign q23 = regs[23];
  assign q24 = regs[24];
  assign q25 = regs[25];
  assign q26 = regs[26];
  assign q27 = regs[27];
  assign q28 = regs[28];
  assign q29 = regs[29];
  assign q30 = regs[30];
  assign q31 = regs[31];

  a_wr_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wr_en));
  a_clr_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(clr_en));
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n) (wr_en & clr_en) == '0);
  a_zero_reg: assert property (@(posedge clk) disable iff (!rst_n)
                               (ZERO_REG == 0) || (regs[0] == '0));

endmodule

// File: tb/tb_regfile_write_bank.sv
// Bench for regfile_write_bank: two instances (ZERO_REG=1 and 0) share stimulus and
// are compared every cycle against an array/countdown model, plus literal spot checks.
module tb_regfile_write_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clear_req;
  logic        ready_a, busy_a, ready_b, busy_b;
  logic [31:0] qa [32];
  logic [31:0] qb [32];

  int errors = 0;
  int checks = 0;

  // Model: m[] is the ordinary bank, left = remaining sweep cycles (0 = idle).
  logic [31:0] m [32];
  int          left;

  always #5 clk = ~clk;

  regfile_write_bank #(.N(32), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready_a),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req), .busy(busy_a),
    .q00(qa[0]),  .q01(qa[1]),  .q02(qa[2]),  .q03(qa[3]),
    .q04(qa[4]),  .q05(qa[5]),  .q06(qa[6]),  .q07(qa[7]),
    .q08(qa[8]),  .q09(qa[9]),  .q10(qa[10]), .q11(qa[11]),
    .q12(qa[12]), .q13(qa[13]), .q14(qa[14]), .q15(qa[15]),
    .q16(qa[16]), .q17(qa[17]), .q18(qa[18]), .q19(qa[19]),
    .q20(qa[20]), .q21(qa[21]), .q22(qa[22]), .q23(qa[23]),
    .q24(qa[24]), .q25(qa[25]), .q26(qa[26]), .q27(qa[27]),
    .q28(qa[28]), .q29(qa[29]), .q30(qa[30]), .q31(qa[31])
  );

  regfile_write_bank #(.N(32), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(ready_b),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req), .busy(busy_b),
    .q00(qb[0]),  .q01(qb[1]),  .q02(qb[2]),  .q03(qb[3]),
    .q04(qb[4]),  .q05(qb[5]),  .q06(qb[6]),  .q07(qb[7]),
    .q08(qb[8]),  .q09(qb[9]),  .q10(qb[10]), .q11(qb[11]),
    .q12(qb[12]), .q13(qb[13]), .q14(qb[14]), .q15(qb[15]),
    .q16(qb[16]), .q17(qb[17]), .q18(qb[18]), .q19(qb[19]),
    .q20(qb[20]), .q21(qb[21]), .q22(qb[22]), .q23(qb[23]),
    .q24(qb[24]), .q25(qb[25]), .q26(qb[26]), .q27(qb[27]),
    .q28(qb[28]), .q29(qb[29]), .q30(qb[30]), .q31(qb[31])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      left = 0;
    end else if (left > 0) begin
      m[32 - left] = '0;
      left = left - 1;
    end else if (clear_req) begin
      left = 32;
    end else if (wr_valid) begin
      m[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_a", {31'b0, busy_a}, {31'b0, left > 0});
      chk("busy_b", {31'b0, busy_b}, {31'b0, left > 0});
      chk("ready_a", {31'b0, ready_a}, {31'b0, (left == 0) && !clear_req});
      chk("ready_b", {31'b0, ready_b}, {31'b0, (left == 0) && !clear_req});
      for (int i = 0; i < 32; i++) begin
        chk($sformatf("qa[%0d]", i), qa[i], (i == 0) ? 32'h0 : m[i]);
        chk($sformatf("qb[%0d]", i), qb[i], m[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    int first_ready;
    int waited;

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_busy", {31'b0, busy_a}, 32'h0);
    chk("rst_ready", {31'b0, ready_a}, 32'h1);
    for (int i = 0; i < 32; i++) chk($sformatf("rst_q%0d", i), qb[i], 32'h0);

    // Single write, 1-cycle latency
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("wr5_q05", qa[5], 32'hDEADBEEF);
    chk("wr5_q04", qa[4], 32'h0);
    chk("wr5_ready", {31'b0, ready_a}, 32'h1);

    // Writes to address 0: discarded when hardwired, kept otherwise
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("wr0_ready_a", {31'b0, ready_a}, 32'h1);
    chk("wr0_ready_b", {31'b0, ready_b}, 32'h1);
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("wr0_qa0", qa[0], 32'h0);
    chk("wr0_qb0", qb[0], 32'hFFFFFFFF);

    // Back-to-back writes i=1..31
    @(posedge clk); #1;
    for (int i = 1; i < 32; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("b2b_q01", qa[1], 32'h01010101);
    chk("b2b_q05", qa[5], 32'h05050505);
    chk("b2b_q31", qa[31], 32'h1F1F1F1F);
    for (int i = 1; i < 32; i++) chk($sformatf("b2b_q%0d", i), qb[i], 32'(i) * 32'h01010101);

    // Bulk clear from a full bank
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    busy_cnt = 0; first_ready = 0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (ready_a && first_ready == 0) first_ready = k;
      if (k == 16) begin
        chk("clr_mid_q14", qb[14], 32'h0);
        chk("clr_mid_q15", qb[15], 32'h0F0F0F0F);
      end
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("clr_first_ready", 32'(first_ready), 32'd33);
    for (int i = 0; i < 32; i++) chk($sformatf("clr_q%0d", i), qb[i], 32'h0);

    // Write colliding with clear_req is held until the sweep finishes
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234; clear_req = 1'b1;
    @(negedge clk);
    chk("coll_ready", {31'b0, ready_a}, 32'h0);
    @(posedge clk); #1 clear_req = 1'b0;
    waited = 1;
    while (waited < 40) begin
      @(negedge clk);
      if (ready_a) break;
      waited++;
    end
    chk("coll_wait_cycles", 32'(waited), 32'd33);
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("coll_q07", qa[7], 32'h1234);
    for (int i = 0; i < 32; i++)
      if (i != 7) chk($sformatf("coll_q%0d", i), qb[i], 32'h0);

    // Fill a few registers, then abort a clear with reset
    @(posedge clk); #1;
    for (int i = 20; i < 24; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(i); wr_data = 32'hA0000000 | 32'(i);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy_a", {31'b0, busy_a}, 32'h0);
    chk("abort_busy_b", {31'b0, busy_b}, 32'h0);
    chk("abort_q07", qa[7], 32'h0);
    chk("abort_q21", qb[21], 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'b0, ready_a}, 32'h1);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000A5A5;
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_q09", qa[9], 32'h0000A5A5);
    chk("post_rst_q22", qa[22], 32'h0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
